// File: rtl/assemble_pkg.sv
// Shared types for the byte-to-block assembler and its downstream serializer.
//   asm_state_t      : FILL (collecting bytes) / HOLD (block presented)
//   BLOCK_BYTES_DEF  : default bytes per block
//   BYTE_W_DEF       : default bits per byte
//   block_t          : packed block layout used by both the assembler and the serializer
package assemble_pkg;

  typedef enum logic {FILL, HOLD} asm_state_t;

  localparam int BLOCK_BYTES_DEF = 16;
  localparam int BYTE_W_DEF      = 8;

  typedef logic [BLOCK_BYTES_DEF-1:0][BYTE_W_DEF-1:0] block_t;

endpackage

// File: rtl/assemble_block_pad_fill.sv
// pad_fill: combinational padder for a partially filled block.
// Data occupies the top i_count slots (index BLOCK_BYTES-1 downward). Every slot
// below that is overwritten with the pad value.
// Build option ASSEMBLE_BLOCK_PKCS7_EN:
//   defined   : pad byte = BLOCK_BYTES - i_count (PKCS#7); an empty flush is allowed
//   undefined : pad byte = 0x00; an empty flush must be ignored
// Ports:
//   i_block    in   current block including any byte accepted this cycle
//   i_count    in   byte count after that accept
//   o_block    out  padded block
//   o_empty_ok out  1 if a flush with no data bytes produces a block
module pad_fill
  import assemble_pkg::*;
#(
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
  parameter int BYTE_W      = BYTE_W_DEF,
  parameter int CW          = $clog2(BLOCK_BYTES) + 1
) (
  input  logic [BLOCK_BYTES-1:0][BYTE_W-1:0] i_block,
  input  logic [CW-1:0]                      i_count,
  output logic [BLOCK_BYTES-1:0][BYTE_W-1:0] o_block,
  output logic                               o_empty_ok
);

  logic [BYTE_W-1:0] w_pad;

`ifdef ASSEMBLE_BLOCK_PKCS7_EN
  // Pad value is the number of pad bytes; BLOCK_BYTES <= 255 keeps it in a byte.
  assign w_pad      = BYTE_W'(BLOCK_BYTES - int'(i_count));
  assign o_empty_ok = 1'b1;
`else
  assign w_pad      = '0;
  assign o_empty_ok = 1'b0;
`endif

  // Slot i is padding when it lies below the last data byte: i < BLOCK_BYTES - count.
  always_comb begin
    o_block = i_block;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (i + int'(i_count) < BLOCK_BYTES) o_block[i] = w_pad;
    end
  end

endmodule

// File: rtl/assemble_block.sv
// assemble_block: packs a byte stream into one BLOCK_BYTES block, first byte at the
// highest index, and holds the finished block under valid/ready until taken.
// Padding behaviour depends on ASSEMBLE_BLOCK_PKCS7_EN (handled inside pad_fill).
// Ports:
//   clk_in          in   clock
//   rst_in          in   synchronous reset, active-low
//   byte_in         in   input byte
//   byte_valid_in   in   byte_in valid
//   byte_ready_out  out  byte accepted this cycle when valid
//   flush_in        in   close a partial block (pad and present it)
//   block_out       out  packed block [BLOCK_BYTES-1:0][BYTE_W-1:0]
//   block_valid_out out  block_out complete and stable
//   block_ready_in  in   downstream takes block_out this cycle
//   byte_count_out  out  bytes currently stored, 0..BLOCK_BYTES
// BLOCK_BYTES must be a power of two, at least 2.
module assemble_block
  import assemble_pkg::*;
#(
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
  parameter int BYTE_W      = BYTE_W_DEF
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [BYTE_W-1:0]                    byte_in,
  input  logic                                 byte_valid_in,
  output logic                                 byte_ready_out,
  input  logic                                 flush_in,
  output logic [BLOCK_BYTES-1:0][BYTE_W-1:0]   block_out,
  output logic                                 block_valid_out,
  input  logic                                 block_ready_in,
  output logic [$clog2(BLOCK_BYTES):0]         byte_count_out
);

  localparam int CW = $clog2(BLOCK_BYTES) + 1;

  asm_state_t                        r_state;
  logic [BLOCK_BYTES-1:0][BYTE_W-1:0] r_block;
  logic [CW-1:0]                     r_count;
  // Low only in the cycle(s) of reset, so ready rises one edge after reset ends.
  logic                              r_live;

  asm_state_t                        w_state_nxt;
  logic [BLOCK_BYTES-1:0][BYTE_W-1:0] w_block_nxt;
  logic [CW-1:0]                     w_count_nxt;
  logic                              w_acc;
  logic [BLOCK_BYTES-1:0][BYTE_W-1:0] w_blk_data;
  logic [BLOCK_BYTES-1:0][BYTE_W-1:0] w_blk_pad;
  logic [CW-1:0]                     w_cnt_data;
  logic                              w_empty_ok;

  assign byte_ready_out  = r_live && (r_state == FILL);
  assign block_valid_out = (r_state == HOLD);
  assign block_out       = r_block;
  assign byte_count_out  = r_count;

  assign w_acc      = byte_valid_in && byte_ready_out;
  assign w_cnt_data = r_count + CW'(w_acc);

  // Block with this cycle's byte written at index BLOCK_BYTES-1-count.
  always_comb begin
    w_blk_data = r_block;
    if (w_acc) begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        if (CW'(BLOCK_BYTES - 1 - i) == r_count) w_blk_data[i] = byte_in;
      end
    end
  end

  // Padding sees the post-accept block so a byte arriving with flush is kept.
  pad_fill #(
    .BLOCK_BYTES (BLOCK_BYTES),
    .BYTE_W      (BYTE_W),
    .CW          (CW)
  ) u_pad (
    .i_block    (w_blk_data),
    .i_count    (w_cnt_data),
    .o_block    (w_blk_pad),
    .o_empty_ok (w_empty_ok)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_block_nxt = r_block;
    w_count_nxt = r_count;
    case (r_state)
      FILL: begin
        if (r_live) begin
          w_block_nxt = w_blk_data;
          w_count_nxt = w_cnt_data;
          if (w_cnt_data == CW'(BLOCK_BYTES)) begin
            // Full by data alone; a simultaneous flush has nothing to pad.
            w_state_nxt = HOLD;
          end else if (flush_in && ((w_cnt_data != '0) || w_empty_ok)) begin
            w_block_nxt = w_blk_pad;
            w_count_nxt = CW'(BLOCK_BYTES);
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (block_ready_in) begin
          w_state_nxt = FILL;
          w_block_nxt = '0;
          w_count_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= FILL;
      r_block <= '0;
      r_count <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_block <= w_block_nxt;
      r_count <= w_count_nxt;
      r_live  <= 1'b1;
    end
  end

endmodule
